// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//   Command-driven controller for a single register datapath instance.
//   A command is accepted on a valid/ready handshake. It is then expanded
//   into a sequence of register strobes, one strobe per cycle. A one-cycle
//   done pulse closes every accepted command.
//
//   FSM: IDLE -> RUN -> DONE -> IDLE.
//   Commands with no strobes (NOP, or a zero repeat count) go straight from
//   IDLE to DONE.
//
// Parameters
//   DATA_WIDTH  register data width (cmd_data, reg_in, reg_q)
//   CNT_WIDTH   repeat count width; the largest repeat is 2**CNT_WIDTH-1
//
// Ports
//   clk, rst_n               clock (rising edge), async active-low reset
//   cmd_valid / cmd_ready    command handshake; cmd_ready is high in IDLE only
//   cmd_op                   0 NOP, 1 CLR, 2 LOAD, 3 INC, 4 DEC,
//                            5 SHR, 6 SHL, 7 ROR
//   cmd_cnt                  repeat count for INC/DEC/SHR/SHL/ROR
//   cmd_data                 load value for LOAD
//   cmd_fill                 serial fill bit for SHR/SHL
//   abort                    synchronous abort of a command in RUN
//   reg_q                    live register value (read only by ROR)
//   reg_cl .. reg_sl         register strobes
//   reg_in                   register parallel input (LOAD only)
//   reg_ir / reg_il          serial fill to the register
//   busy                     high in RUN and DONE
//   done                     one-cycle completion pulse
//
// Configuration
//   REG_OP_SEQ_ROR_EN  When defined, op 7 rotates right. Each RUN cycle
//                      strobes reg_sr with reg_ir = reg_q[0].
//                      When undefined, op 7 behaves as NOP.
// ---------------------------------------------------------------------------
module reg_op_sequencer #(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [2:0]            cmd_op,
  input  logic [CNT_WIDTH-1:0]  cmd_cnt,
  input  logic [DATA_WIDTH-1:0] cmd_data,
  input  logic                  cmd_fill,
  input  logic                  abort,
  input  logic [DATA_WIDTH-1:0] reg_q,
  output logic                  reg_cl,
  output logic                  reg_ld,
  output logic                  reg_inc,
  output logic                  reg_dec,
  output logic                  reg_sr,
  output logic                  reg_sl,
  output logic [DATA_WIDTH-1:0] reg_in,
  output logic                  reg_ir,
  output logic                  reg_il,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {
    OP_NOP  = 3'd0,
    OP_CLR  = 3'd1,
    OP_LOAD = 3'd2,
    OP_INC  = 3'd3,
    OP_DEC  = 3'd4,
    OP_SHR  = 3'd5,
    OP_SHL  = 3'd6,
    OP_ROR  = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

  state_t                state;
  op_t                   op_q;
  logic [CNT_WIDTH-1:0]  rem_q;
  logic [DATA_WIDTH-1:0] data_q;
  logic                  fill_q;

  op_t                   new_op;
  logic [CNT_WIDTH-1:0]  new_cnt;
  logic                  strobe_active;

  assign new_op = op_t'(cmd_op);

  // Effective strobe count of the incoming command. Ops that emit no strobes
  // report 0, so a non-zero count alone decides between RUN and DONE.
  always_comb begin
    new_cnt = '0;
    case (new_op)
      OP_CLR, OP_LOAD:                 new_cnt = CNT_ONE;
      OP_INC, OP_DEC, OP_SHR, OP_SHL:  new_cnt = cmd_cnt;
`ifdef REG_OP_SEQ_ROR_EN
      OP_ROR:                          new_cnt = cmd_cnt;
`endif
      default:                         new_cnt = '0;
    endcase
  end

  // Control FSM together with the captured command fields.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      op_q   <= OP_NOP;
      rem_q  <= '0;
      data_q <= '0;
      fill_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            op_q   <= new_op;
            data_q <= cmd_data;
            fill_q <= cmd_fill;
            if (new_cnt != '0) begin
              state <= RUN;
              rem_q <= new_cnt;
            end else begin
              state <= DONE;
              rem_q <= '0;
            end
          end
        end
        RUN: begin
          if (abort || rem_q == CNT_ONE) begin
            state <= DONE;
            rem_q <= '0;
          end else begin
            rem_q <= rem_q - CNT_ONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Strobes come from registered state only. abort is the single live
  // qualifier: it suppresses the strobe in the same cycle it is raised.
  assign strobe_active = (state == RUN) && !abort;

  always_comb begin
    reg_cl  = 1'b0;
    reg_ld  = 1'b0;
    reg_inc = 1'b0;
    reg_dec = 1'b0;
    reg_sr  = 1'b0;
    reg_sl  = 1'b0;
    reg_in  = '0;
    reg_ir  = 1'b0;
    reg_il  = 1'b0;
    if (strobe_active) begin
      case (op_q)
        OP_CLR:  reg_cl  = 1'b1;
        OP_LOAD: begin
          reg_ld = 1'b1;
          reg_in = data_q;
        end
        OP_INC:  reg_inc = 1'b1;
        OP_DEC:  reg_dec = 1'b1;
        OP_SHR: begin
          reg_sr = 1'b1;
          reg_ir = fill_q;
        end
        OP_SHL: begin
          reg_sl = 1'b1;
          reg_il = fill_q;
        end
`ifdef REG_OP_SEQ_ROR_EN
        // Rotate is a right shift that feeds the live LSB back in at the top.
        OP_ROR: begin
          reg_sr = 1'b1;
          reg_ir = reg_q[0];
        end
`endif
        default: begin
          reg_cl = 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready = (state == IDLE);
  assign busy      = (state == RUN) || (state == DONE);
  assign done      = (state == DONE);

  // reg_q is kept on the port list in every build. Only its LSB feeds the
  // rotate, so the remaining bits are folded into a sink.
`ifdef REG_OP_SEQ_ROR_EN
  logic reg_q_unused;
  assign reg_q_unused = ^reg_q[DATA_WIDTH-1:1];
`else
  logic reg_q_unused;
  assign reg_q_unused = ^reg_q;
`endif

endmodule

// File: tb/tb_reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_op_sequencer
//   Self-checking bench for reg_op_sequencer. A simple register, driven by
//   the strobes, closes the loop through reg_q. Expected strobe timelines and
//   register values come from an arithmetic model of each command.
//   The macro REG_OP_SEQ_ROR_EN is honoured in the same way as in the design.
// ---------------------------------------------------------------------------
module tb_reg_op_sequencer;

  localparam int W  = 16;
  localparam int CW = 5;
`ifdef REG_OP_SEQ_ROR_EN
  localparam bit ROR_EN = 1'b1;
`else
  localparam bit ROR_EN = 1'b0;
`endif

  localparam logic [2:0] NOP = 3'd0, CLR = 3'd1, LOAD = 3'd2, INC = 3'd3,
                         DEC = 3'd4, SHR = 3'd5, SHL = 3'd6, ROR = 3'd7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic [2:0]    cmd_op = '0;
  logic [CW-1:0] cmd_cnt = '0;
  logic [W-1:0]  cmd_data = '0;
  logic          cmd_fill = 1'b0;
  logic          abort = 1'b0;
  logic          cmd_ready, reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl;
  logic          reg_ir, reg_il, busy, done;
  logic [W-1:0]  reg_in;
  logic [W-1:0]  dut_reg = '0;

  int            checks = 0;
  int            failures = 0;
  logic [W-1:0]  ref_val = '0;

  always #5 clk = ~clk;

  reg_op_sequencer #(.DATA_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_cnt(cmd_cnt), .cmd_data(cmd_data),
    .cmd_fill(cmd_fill), .abort(abort), .reg_q(dut_reg),
    .reg_cl(reg_cl), .reg_ld(reg_ld), .reg_inc(reg_inc), .reg_dec(reg_dec),
    .reg_sr(reg_sr), .reg_sl(reg_sl), .reg_in(reg_in),
    .reg_ir(reg_ir), .reg_il(reg_il), .busy(busy), .done(done)
  );

  // The controlled register, not reset by rst_n.
  always @(posedge clk) begin
    if (reg_cl)       dut_reg <= '0;
    else if (reg_ld)  dut_reg <= reg_in;
    else if (reg_inc) dut_reg <= dut_reg + 1'b1;
    else if (reg_dec) dut_reg <= dut_reg - 1'b1;
    else if (reg_sr)  dut_reg <= {reg_ir, dut_reg[W-1:1]};
    else if (reg_sl)  dut_reg <= {dut_reg[W-2:0], reg_il};
  end

  function automatic logic [31:0] pack(input logic [5:0] stb, input logic ir,
      input logic il, input logic dn, input logic bz, input logic rdy,
      input logic [W-1:0] din);
    return {5'b0, stb, ir, il, dn, bz, rdy, din};
  endfunction

  function automatic logic [31:0] obs();
    return pack({reg_cl, reg_ld, reg_inc, reg_dec, reg_sr, reg_sl},
                reg_ir, reg_il, done, busy, cmd_ready, reg_in);
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%08h expected=%08h", tag, o, e);
    end
  endtask

  function automatic int unsigned strobes_for(input logic [2:0] op, input int unsigned cnt);
    case (op)
      CLR, LOAD:           return 1;
      INC, DEC, SHR, SHL:  return cnt;
      ROR:                 return ROR_EN ? cnt : 0;
      default:             return 0;
    endcase
  endfunction

  function automatic logic [W-1:0] ror(input logic [W-1:0] r, input int unsigned m);
    logic [2*W-1:0] d;
    d = {r, r} >> (m % W);
    return d[W-1:0];
  endfunction

  // Register value after n strobes of op starting from r.
  function automatic logic [W-1:0] apply(input logic [2:0] op, input logic [W-1:0] r,
      input int unsigned n, input logic [W-1:0] data, input logic fill);
    logic [63:0] v;
    case (op)
      CLR:  return (n > 0) ? '0 : r;
      LOAD: return (n > 0) ? data : r;
      INC:  return W'(32'(r) + n);
      DEC:  return W'(32'(r) - n);
      SHR: begin
        v = fill ? {48'hFFFF_FFFF_FFFF, r} : {48'h0, r};
        v = v >> n;
        return v[W-1:0];
      end
      SHL: begin
        v = {48'h0, r} << n;
        if (fill) v = v | ((64'h1 << n) - 64'h1);
        return v[W-1:0];
      end
      ROR:  return ror(r, n);
      default: return r;
    endcase
  endfunction

  // Expected outputs in cycle k after accept: s strobes, done in cycle d.
  function automatic logic [31:0] exp_vec(input logic [2:0] op, input int unsigned k,
      input int unsigned s, input int unsigned d, input logic [W-1:0] data,
      input logic fill, input logic [W-1:0] r0);
    logic [5:0]   stb;
    logic         ir, il;
    logic [W-1:0] din, rr;
    stb = '0; ir = 1'b0; il = 1'b0; din = '0;
    if (k <= s) begin
      case (op)
        CLR:  stb = 6'b100000;
        LOAD: begin stb = 6'b010000; din = data; end
        INC:  stb = 6'b001000;
        DEC:  stb = 6'b000100;
        SHR:  begin stb = 6'b000010; ir = fill; end
        SHL:  begin stb = 6'b000001; il = fill; end
        ROR:  begin stb = 6'b000010; rr = ror(r0, k - 1); ir = rr[0]; end
        default: stb = '0;
      endcase
    end
    return pack(stb, ir, il, k == d, k <= d, k > d, din);
  endfunction

  // Issue one command; abort_at=k raises abort in cycle k (0 = never).
  task automatic run_cmd(input logic [2:0] op, input int unsigned cnt,
      input logic [W-1:0] data, input logic fill, input int unsigned abort_at,
      input string tag);
    int unsigned n, s, d;
    logic [W-1:0] r0;
    n = strobes_for(op, cnt);
    if (abort_at >= 1 && abort_at <= n) begin
      s = abort_at - 1;
      d = abort_at + 1;
    end else begin
      s = n;
      d = n + 1;
    end
    r0 = ref_val;
    ref_val = apply(op, r0, s, data, fill);
    #2;
    cmd_valid = 1'b1; cmd_op = op; cmd_cnt = CW'(cnt);
    cmd_data = data; cmd_fill = fill; abort = 1'b0;
    @(posedge clk);
    for (int unsigned k = 1; k <= d + 1; k++) begin
      #2;
      abort     = (k == abort_at);
      cmd_valid = (k <= d) ? 1'($urandom_range(0, 1)) : 1'b0;
      cmd_op    = 3'($urandom);
      cmd_cnt   = CW'($urandom);
      cmd_data  = W'($urandom);
      cmd_fill  = 1'($urandom);
      @(negedge clk);
      chk({tag, " seq"}, obs(), exp_vec(op, k, s, d, data, fill, r0));
      if (k == d + 1) chk({tag, " reg"}, 32'(dut_reg), 32'(ref_val));
      @(posedge clk);
    end
  endtask

  initial begin : main
    logic [W-1:0] r0;
    logic [2:0]   op;
    int unsigned  n, c, ab;

    #12;
    chk("reset", obs(), pack(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    run_cmd(LOAD, 0, 16'h1234, 1'b0, 0, "load");
    chk("load const", 32'(dut_reg), 32'h1234);
    run_cmd(LOAD, 0, 16'h0001, 1'b0, 0, "load1");
    run_cmd(SHL, 4, '0, 1'b1, 0, "shl4");
    chk("shl4 const", 32'(dut_reg), 32'h001F);
    run_cmd(INC, 0, '0, 1'b0, 0, "inc0");
    chk("inc0 const", 32'(dut_reg), 32'h001F);
    run_cmd(LOAD, 0, 16'h0000, 1'b0, 0, "load0");
    run_cmd(DEC, 1, '0, 1'b0, 0, "dec1");
    chk("dec1 const", 32'(dut_reg), 32'hFFFF);
    run_cmd(SHR, 10, '0, 1'b0, 4, "shr_abort");
    chk("shr_abort const", 32'(dut_reg), 32'h1FFF);

    // Reset in the middle of an 8-strobe SHL.
    r0 = ref_val;
    #2;
    cmd_valid = 1'b1; cmd_op = SHL; cmd_cnt = CW'(8); cmd_fill = 1'b1;
    @(posedge clk);
    for (int unsigned k = 1; k <= 3; k++) begin
      #2;
      cmd_valid = 1'b0;
      @(negedge clk);
      chk("rst_run seq", obs(), exp_vec(SHL, k, 8, 9, '0, 1'b1, r0));
      @(posedge clk);
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid", obs(), pack(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    ref_val = apply(SHL, r0, 3, '0, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("rst_after", obs(), pack(6'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, '0));
    end
    chk("rst reg", 32'(dut_reg), 32'(ref_val));

    run_cmd(LOAD, 0, 16'h0001, 1'b0, 0, "load1b");
    run_cmd(ROR, 1, '0, 1'b0, 0, "ror1");
    chk("ror1 const", 32'(dut_reg), ROR_EN ? 32'h8000 : 32'h0001);
    run_cmd(CLR, 7, '0, 1'b0, 0, "clr");
    run_cmd(NOP, 5, 16'hBEEF, 1'b1, 0, "nop");
    run_cmd(INC, 31, '0, 1'b0, 0, "inc_max");
    run_cmd(INC, 0, '0, 1'b0, 1, "abort_in_done");
    run_cmd(SHL, 3, '0, 1'b0, 4, "abort_in_done2");

    for (int unsigned i = 0; i < 80; i++) begin
      op = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 9))
        0:       c = 0;
        1:       c = 31;
        default: c = $urandom_range(1, 12);
      endcase
      n  = strobes_for(op, c);
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, n + 1) : 0;
      run_cmd(op, c, W'($urandom), 1'($urandom), ab, "rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
